// File: rtl/fetch_ifid.sv
// fetch_ifid
// ----------
// Fetch stage plus IF/ID pipeline register feeding decode directly.
// The PC lives here. One instruction-memory request is in flight at a time,
// and memory latency is variable. A response that arrives while decode is
// stalled is parked in a one-entry skid buffer. Fetch stops after an
// instruction with opcode 00000 (HALT) and restarts only on a redirect.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous reset, active-low
//   stall_ID     decode cannot accept; IF/ID holds its contents
//   redirect     taken branch/jump from a later stage; flushes fetch
//   redirect_PC  new PC, valid while redirect=1
//   imem_req     one-cycle request pulse to instruction memory
//   imem_addr    fetch address (always the current PC)
//   imem_rdata   returned instruction, valid while imem_done=1
//   imem_done    response strobe from instruction memory
//   inst_ID      IF/ID instruction (NOP_INST when invalid)
//   PC_inc_ID    IF/ID PC+2 of that instruction
//   valid_ID     IF/ID holds a real instruction
//   err          sticky error flag (odd redirect target or unexpected response)
module fetch_ifid #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_ID,
    input  logic        redirect,
    input  logic [15:0] redirect_PC,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] inst_ID,
    output logic [15:0] PC_inc_ID,
    output logic        valid_ID,
    output logic        err
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] skid_q, skid_d;
    logic [15:0] inst_q, inst_d;
    logic [15:0] pcInc_q, pcInc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        deliver;
    logic [15:0] deliverInst;
    logic        forceBubble;
    logic [15:0] pcPlus2;

    // Memory-facing outputs come straight from registers so that no input
    // can ripple combinationally into the request.
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign inst_ID   = inst_q;
    assign PC_inc_ID = pcInc_q;
    assign valid_ID  = valid_q;
    assign err       = err_q;

    assign pcPlus2 = pc_q + 16'd2;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        skid_d      = skid_q;
        inst_d      = inst_q;
        pcInc_d     = pcInc_q;
        valid_d     = valid_q;
        err_d       = err_q;
        deliver     = 1'b0;
        deliverInst = skid_q;
        forceBubble = 1'b0;

        case (state_q)
            S_BOOT: begin
                // Boot never flushes IF/ID; a redirect here only moves the PC.
                state_d = S_REQ;
                if (redirect) begin
                    pc_d = redirect_PC;
                end
            end
            S_REQ: begin
                // The request has just gone out, so a redirect must drain it.
                if (redirect) begin
                    pc_d        = redirect_PC;
                    forceBubble = 1'b1;
                    state_d     = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // A response landing with the redirect is simply dropped.
                    pc_d        = redirect_PC;
                    forceBubble = 1'b1;
                    state_d     = imem_done ? S_REQ : S_DRAIN;
                end else if (imem_done) begin
                    if (stall_ID) begin
                        skid_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        deliver     = 1'b1;
                        deliverInst = imem_rdata;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d        = redirect_PC;
                    forceBubble = 1'b1;
                    state_d     = S_REQ;
                end else if (!stall_ID) begin
                    deliver = 1'b1;
                end
            end
            S_DRAIN: begin
                // The outstanding response is discarded whenever it shows up.
                if (redirect) begin
                    pc_d        = redirect_PC;
                    forceBubble = 1'b1;
                end
                if (imem_done) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                if (redirect) begin
                    pc_d        = redirect_PC;
                    forceBubble = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // IF/ID load: a delivered instruction wins, otherwise a bubble unless
        // decode is stalled (redirect flushes even through a stall).
        if (deliver) begin
            inst_d  = deliverInst;
            pcInc_d = pcPlus2;
            valid_d = 1'b1;
            pc_d    = pcPlus2;
            state_d = (deliverInst[15:11] == 5'b00000) ? S_HALT : S_REQ;
        end else if (forceBubble || !stall_ID) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end

        // Only WAIT and DRAIN expect a response.
        if ((redirect && redirect_PC[0]) ||
            (imem_done && (state_q == S_BOOT || state_q == S_REQ ||
                           state_q == S_HOLD || state_q == S_HALT))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            skid_q  <= 16'h0000;
            inst_q  <= NOP_INST;
            pcInc_q <= 16'h0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            inst_q  <= inst_d;
            pcInc_q <= pcInc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule
